// File: rtl/logic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : logic_seq_ctrl (with nor_gate_8bit slice)
// Purpose  : Byte-serial 32-bit NOR/OR/AND/NAND unit built around a single
//            8-bit NOR slice. Operand and result inversion around the slice
//            yields the other three functions. Start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================

// Shared 8-bit NOR slice: the only logic gate in the datapath.
module nor_gate_8bit (
  input  logic [7:0] n1,
  input  logic [7:0] n2,
  output logic [7:0] y
);
  assign y = ~(n1 | n2);
endmodule

module logic_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  byte_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [1:0]  r_op;
  logic        w_accept;
  logic [7:0]  w_a_byte;
  logic [7:0]  w_b_byte;
  logic [7:0]  w_n1;
  logic [7:0]  w_n2;
  logic [7:0]  w_nor;
  logic [7:0]  w_byte;

  // A new operation is only taken when the slice is not being sequenced.
  assign w_accept = start && (r_state != S_RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; DONE lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == 2'd3) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = w_accept ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Select the byte of each latched operand addressed by the counter.
  always_comb begin
    w_a_byte = r_a[7:0];
    w_b_byte = r_b[7:0];
    case (r_cnt)
      2'd0: begin w_a_byte = r_a[7:0];   w_b_byte = r_b[7:0];   end
      2'd1: begin w_a_byte = r_a[15:8];  w_b_byte = r_b[15:8];  end
      2'd2: begin w_a_byte = r_a[23:16]; w_b_byte = r_b[23:16]; end
      default: begin w_a_byte = r_a[31:24]; w_b_byte = r_b[31:24]; end
    endcase
  end

  // op[1] selects AND-family (De Morgan: inverted inputs into NOR);
  // op[0] inverts the slice output (NOR->OR, AND->NAND).
  assign w_n1   = r_op[1] ? ~w_a_byte : w_a_byte;
  assign w_n2   = r_op[1] ? ~w_b_byte : w_b_byte;
  assign w_byte = r_op[0] ? ~w_nor : w_nor;

  nor_gate_8bit u_slice (
    .n1 (w_n1),
    .n2 (w_n2),
    .y  (w_nor)
  );

  // Operand capture, byte counter and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_a    <= 32'd0;
      r_b    <= 32'd0;
      r_op   <= 2'd0;
      result <= 32'd0;
    end else if (w_accept) begin
      r_cnt  <= 2'd0;
      r_a    <= a;
      r_b    <= b;
      r_op   <= op;
      result <= 32'd0;
    end else if (r_state == S_RUN) begin
      r_cnt                  <= r_cnt + 2'd1;
      result[8*r_cnt +: 8]   <= w_byte;
    end
  end

  assign byte_idx = (r_state == S_RUN) ? r_cnt : 2'd0;

endmodule
`default_nettype wire

// File: doc/logic_seq_ctrl.md
Name: logic_seq_ctrl

Overview:
Byte-serial sequencer that computes a 32-bit bitwise logic result using a single shared nor_gate_8bit slice over four cycles.
Supports NOR, OR, AND and NAND: the NOR slice is the only gate, with operand and result inversion applied around it.
It is the area-reduced alternative to the parallel 32-bit NOR unit, and sits in the ALU logic path behind a start/done handshake.

Parameters:
None. Widths are fixed: 32-bit operands, 8-bit slice, 4 slice passes.

Ports:
clk      input   1   system clock, all state updates on rising edge
rst      input   1   synchronous reset, active-high
start    input   1   request a new operation; accepted only when busy=0
op       input   2   00 NOR, 01 OR, 10 AND, 11 NAND; sampled at accept
a        input   32  operand A; sampled at accept
b        input   32  operand B; sampled at accept
busy     output  1   1 while the slice is being sequenced (RUN state)
done     output  1   one-cycle pulse: result valid
result   output  32  final result; held stable from done until the next accept
byte_idx output  2   byte currently fed to the slice (debug); 0 outside RUN

Behaviour:
- One clock, synchronous active-high reset.
- Reset (rst=1 at an edge), from any state including mid-RUN:
  - state=IDLE, cnt=0, busy=0, done=0, result=0.
  - Latched operands and op cleared to 0.
  - An in-flight operation is discarded; no done is produced for it.
- States: IDLE, RUN, DONE.
- Accept condition: start=1 and state is IDLE or DONE, sampled at an edge. On accept:
  - Latch a, b and op.
  - result <= 0, cnt <= 0, state <= RUN.
- RUN, slice inputs for byte cnt = bits [8*cnt+7 : 8*cnt]:
  - op 00 (NOR) and 01 (OR): slice n1=a_byte, n2=b_byte.
  - op 10 (AND) and 11 (NAND): slice n1=~a_byte, n2=~b_byte.
- RUN, slice output:
  - Inverted for op 01 (OR) and op 11 (NAND); passed through for op 00 and op 10.
  - The resulting byte is written to result[8*cnt+7 : 8*cnt] at the edge.
- RUN, sequencing:
  - cnt increments each edge.
  - At the edge where cnt=3 the last byte is written and state <= DONE; cnt wraps to 0.
- Latency:
  - Accept at edge E0; bytes 0..3 written at E1..E4.
  - done=1 for exactly the cycle after E4, with result complete in that cycle.
  - busy=1 for the cycles between E0 and E4.
- DONE lasts one cycle:
  - Next state is RUN if start=1 (back-to-back accept), otherwise IDLE.
  - Back-to-back throughput: one operation per 5 cycles.
- start while busy=1 is ignored: latched operands and op are unchanged and no new operation is queued.
- start held high continuously: a new operation is accepted at every DONE cycle.
- Changes to a, b and op after accept have no effect on the operation in flight.
- result holds its last value in IDLE; it changes only on accept (cleared) or on RUN byte writes.
- done and busy are never both 1.
- byte_idx equals cnt in RUN and is 0 otherwise.

Test Plan:
1. Reset, then start with op=00, a=F0F0_1234, b=0F0F_0000 → busy=1 for 4 cycles; done pulse 4 cycles after accept; result=0000_EDCB.
2. op=01 with the same operands → result=FFFF_1234. Then op=10, a=FFFF_0000, b=0F0F_FFFF → result=0F0F_0000. Then op=11 with those operands → result=F0F0_FFFF.
3. Pulse start again mid-RUN with a=0, b=0, op=00 → ignored; first result unchanged (0000_EDCB for scenario 1 operands); no extra done pulse.
4. Hold start=1 continuously; a, b, op change each op (e.g. a=0, b=0, op=00 then op=11) → done every 5 cycles; results FFFF_FFFF then FFFF_FFFF. a=FFFF_FFFF, b=0, op=10 → 0000_0000.
5. Assert rst during RUN at byte_idx=2 → next cycle busy=0, done=0, result=0, IDLE. A following start computes correctly.
6. Change a and b in the cycle after accept (a=1234_5678, b=0, op=01) → result=1234_5678 regardless of the later input values. byte_idx sequence 0,1,2,3 during busy.
